// File: rtl/inv_first_round.sv
// -----------------------------------------------------------------------------
// inv_first_round
//   Byte-serial AES-128 inverse-cipher entry round. The block computes
//   AddRoundKey (round key 10), then InvShiftRows, then InvSubBytes. One
//   combinational inverse S-box is shared across 16 cycles, one byte per cycle.
//
//   State layout: byte k = bits [127-8k -: 8]. The layout is column-major, so
//   byte 4c+r is row r, column c.
//
// Ports
//   clk         in   system clock, rising edge
//   n_rst       in   asynchronous active-low reset
//   start       in   request to process; sampled only while ready=1
//   input_data  in   128-bit ciphertext/state (byte 0 = bits [127:120])
//   keyword     in   128-bit round key 10, same byte order
//   ready       out  high while idle (start is accepted)
//   done        out  one-cycle pulse when result is newly valid
//   result      out  128-bit inverse-round output state
//
// Handshake: start is accepted on a rising edge where ready=1 and start=1.
// Inputs are captured on that edge and are ignored afterwards. done is high
// for exactly one cycle, 17 cycles after acceptance. Any start seen while
// ready=0 is dropped and is not queued.
// -----------------------------------------------------------------------------
module inv_first_round (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic [127:0] input_data,
  input  logic [127:0] keyword,
  output logic         ready,
  output logic         done,
  output logic [127:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  // state is observable hierarchically for checkers
  state_t       state;
  state_t       state_next;
  logic [3:0]   counter;
  logic [127:0] ark;
  logic [127:0] work;

  logic [1:0]   row;
  logic [1:0]   col;
  logic [1:0]   src_col;
  logic [3:0]   src_idx;
  logic [7:0]   sbox_in;
  logic [7:0]   sbox_out;

  // ---------------------------------------------------------------------------
  // GF(2^8) arithmetic with the AES polynomial x^8+x^4+x^3+x+1
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    gf_mul = p;
  endfunction

  // Multiplicative inverse as x^254. The exponent 254 is the sum
  // 2+4+...+128, so the result is the product of the successive squares.
  // This also maps 0 to 0, which is what the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    gf_inv = acc;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    rotl8 = (v << n) | (v >> (8 - n));
  endfunction

  // Inverse S-box: undo the affine map first, then invert in the field.
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] t;
    t        = rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
    inv_sbox = gf_inv(t);
  endfunction

  // ---------------------------------------------------------------------------
  // Source selection implements InvShiftRows. Row r is rotated right by r
  // columns, so output column c takes its byte from source column (c-r) mod 4.
  // The 2-bit subtraction wraps, which gives the mod 4 for free.
  // ---------------------------------------------------------------------------
  assign row     = counter[1:0];
  assign col     = counter[3:2];
  assign src_col = col - row;
  assign src_idx = {src_col, row};

  always_comb begin
    sbox_in = 8'h00;
    for (int k = 0; k < 16; k++) begin
      if (src_idx == k[3:0]) sbox_in = ark[127-8*k -: 8];
    end
  end

  assign sbox_out = inv_sbox(sbox_in);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SUB;
      SUB:     if (counter == 4'd15) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign ready = (state == IDLE);
  assign done  = (state == DONE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      counter <= 4'd0;
      ark     <= 128'h0;
      work    <= 128'h0;
      result  <= 128'h0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            ark     <= input_data ^ keyword;
            counter <= 4'd0;
          end
        end
        SUB: begin
          for (int k = 0; k < 16; k++) begin
            if (counter == k[3:0]) work[127-8*k -: 8] <= sbox_out;
          end
          counter <= counter + 4'd1;
          // On the last byte, publish the full state and bypass byte 15
          // straight from the S-box, so result never shows a partial value.
          if (counter == 4'd15) result <= {work[127:8], sbox_out};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/inv_first_round.md
Name: inv_first_round

Overview:
- Byte-serial AES-128 inverse-cipher entry round: AddRoundKey, then InvShiftRows, then InvSubBytes.
- It is the decryption counterpart of the encrypt-side final round (SubBytes, ShiftRows, AddRoundKey).
- Sits at the front of the decryption datapath. It takes ciphertext and round key 10, and hands the round-9 state to the inverse middle-round logic.
- One shared combinational inv_sbox instance (8-bit in/out) is reused over 16 cycles to save area.

Parameters:
- None. AES-128 only; 16 bytes fixed.

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous, active-low reset.
- start  input  1  request to process; sampled only when ready=1.
- input_data  input  128  ciphertext/state; byte 0 = bits [127:120].
- keyword  input  128  round key 10, same byte order.
- ready  output  1  high while in IDLE (block can accept start).
- done  output  1  one-cycle pulse: result is newly valid.
- result  output  128  inverse-round output state.

Behaviour:
- State layout: byte k = bits [127-8k -: 8]. Column-major: byte 4c+r = row r, column c.
- FSM states: IDLE, SUB, DONE.
- Reset (n_rst=0, asynchronous):
  - state = IDLE, counter = 0, work/key-added registers = 0.
  - result = 128'h0, done = 0, ready = 1.
- Edge E0 (IDLE and start=1):
  - Capture ark = input_data ^ keyword into internal register.
  - counter = 0; state goes to SUB.
  - input_data and keyword are ignored after E0.
- Edges E1..E16 (SUB): on each edge, with j = counter, r = j mod 4, c = j div 4:
  - work byte j <= inv_sbox(ark byte 4*((c-r) mod 4)+r). This is InvShiftRows by source selection.
  - counter increments.
  - On the edge where counter==15: result <= full work value with byte 15 included; state goes to DONE; counter wraps to 0.
- DONE (the cycle after E16):
  - done=1, ready=0.
  - Edge E17 returns to IDLE unconditionally.
- Latency: done is high during the 17th cycle after start is sampled. Throughput is one block per 18 cycles.
- ready = (state==IDLE). done = (state==DONE). Both are decoded from registered state only.
- start while in SUB or DONE: ignored, with no queuing. A start held high across DONE is accepted on the first IDLE cycle.
- result holds the last completed value through IDLE and through any later SUB.
  - result changes only at the end-of-SUB edge or at reset.
  - Partial values are never visible on result.
- Reset asserted mid-SUB or mid-DONE:
  - Immediate return to IDLE with reset values.
  - No done pulse; the partial result is discarded.
- No X propagation: unused bytes are driven from registers, all of which are reset.

Test Plan:
- FIPS-197 C.1 vector: input_data=69c4e0d86a7b0430d8cdb78070b4c55a, keyword=13111d7fe3944a17f307a78b4d2b30c5, start one cycle.
  - Expect ready=0 next cycle.
  - done exactly once, 17 cycles after start.
  - result=bd6e7c3df2b5779e0b61216e8b10b689.
  - result unchanged until the next completion.
- Zero vector: input_data=0, keyword=0 -> result=5252...52 (all 16 bytes 0x52). Then input_data=0, keyword=6363...63 -> result=0.
- Busy rejection: start the C.1 vector, then pulse start with different data at cycles 3 and 16.
  - Expect only one done, with the C.1 result.
  - ready=1 again in the cycle after done.
- Input change after capture: change input_data/keyword every cycle after E0 of the C.1 vector -> result still bd6e7c3d...89.
- Reset mid-operation: assert n_rst=0 at cycle 8 of SUB.
  - Expect immediate result=0, done=0, ready=1.
  - No done pulse follows.
  - A fresh C.1 run afterwards completes correctly.
- Back-to-back: hold start=1 continuously with the C.1 vector, then the zero vector.
  - Expect done pulses 18 cycles apart with the correct results in order.
